// File: rtl/sram_model_param.sv
// Parametrised single-port SRAM model with active-low controls, a tri-state data bus,
// a power-up clear sequencer, a configurable read pipeline and a sticky out-of-range flag.
module sram_model_param #(
  parameter int                DATA_W     = 16,
  parameter int                LANES      = DATA_W / 8,
  parameter int                DEPTH      = 256,
  parameter int                ADDR_W     = 20,
  parameter int                READ_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  inout  wire  [DATA_W-1:0] I_O,
  input  logic [ADDR_W-1:0] A,
  input  logic              CE,
  input  logic [LANES-1:0]  BE_n,
  input  logic              OE,
  input  logic              WE,
  output logic              Ready,
  output logic              Rd_Valid,
  output logic              Addr_Err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe_data [READ_LAT];
  logic [READ_LAT-1:0] pipe_valid;
  logic [DATA_W-1:0] rd_data;

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              wr_en;
  logic              rd_launch;
  logic              bus_en;

  assign idx       = A[IDX_W-1:0];
  assign in_range  = ({1'b0, A} < DEPTH_A);
  assign Ready     = (state == IDLE);
  assign wr_en     = Ready && !CE && !WE;
  assign rd_launch = Ready && !CE && WE && !OE;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == IDX_W'(DEPTH - 1)) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      IDLE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage has no reset; the clear sequencer is the only bulk initialisation.
  always_ff @(posedge Clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= INIT_VALUE;
    end else if (wr_en && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (!BE_n[i]) begin
          mem[idx][8*i +: 8] <= I_O[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_launch;
      for (int s = 1; s < READ_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (rd_launch) begin
      pipe_data[0] <= in_range ? mem[idx] : '0;
    end
    for (int s = 1; s < READ_LAT; s++) begin
      pipe_data[s] <= pipe_data[s-1];
    end
  end

  assign rd_data  = pipe_data[READ_LAT-1];
  assign Rd_Valid = pipe_valid[READ_LAT-1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Addr_Err <= 1'b0;
    end else if ((wr_en || rd_launch) && !in_range) begin
      Addr_Err <= 1'b1;
    end
  end

  // Each lane drives only while the access is still enabled when the data emerges.
  assign bus_en = !CE && !OE && WE && Ready && Rd_Valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign I_O[8*i +: 8] = (bus_en && !BE_n[i]) ? rd_data[8*i +: 8] : 8'bz;
  end

endmodule

// File: tb/tb_sram_model_param.sv
// Directed bench for sram_model_param with a reference memory and a read scoreboard.
// The bus carries a pull-up, so a released lane reads back as all ones.
module tb_sram_model_param;

  localparam int DATA_W   = 16;
  localparam int LANES    = DATA_W / 8;
  localparam int DEPTH    = 256;
  localparam int ADDR_W   = 20;
  localparam int READ_LAT = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic              Clk     = 1'b0;
  logic              Reset_n = 1'b1;
  logic [ADDR_W-1:0] a;
  logic              ce;
  logic              oe;
  logic              we;
  logic [LANES-1:0]  be_n;
  logic [DATA_W-1:0] tb_wdata;
  logic              tb_drv;
  tri1  [DATA_W-1:0] io_bus;
  wire               ready;
  wire               rd_valid;
  wire               addr_err;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                model_err;
  int                clr_cnt;
  int                cycle;
  int                checks;
  int                failures;

  assign io_bus = tb_drv ? tb_wdata : {DATA_W{1'bz}};

  always #5 Clk = ~Clk;

  sram_model_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .READ_LAT  (READ_LAT),
    .INIT_VALUE('0)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .I_O     (io_bus),
    .A       (a),
    .CE      (ce),
    .BE_n    (be_n),
    .OE      (oe),
    .WE      (we),
    .Ready   (ready),
    .Rd_Valid(rd_valid),
    .Addr_Err(addr_err)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  task automatic check_output();
    logic              exp_valid;
    logic [DATA_W-1:0] exp_bus;
    exp_valid = (sb_q.size() > 0) && (sb_q[0].due == cycle);
    check("ready", ready, (clr_cnt >= DEPTH));
    check("rd_valid", rd_valid, exp_valid);
    check("addr_err", addr_err, model_err);
    if (!tb_drv) begin
      exp_bus = '1;
      if (exp_valid && !ce && !oe && we) begin
        for (int i = 0; i < LANES; i++) begin
          if (!be_n[i]) exp_bus[8*i +: 8] = sb_q[0].data[8*i +: 8];
        end
      end
      check("bus", io_bus, exp_bus);
    end
    if (exp_valid) void'(sb_q.pop_front());
  endtask

  // Update the reference model from the controls about to be sampled, then clock once.
  task automatic tick();
    exp_t e;
    if (clr_cnt >= DEPTH && !ce) begin
      if (!we) begin
        if (a < DEPTH) begin
          for (int i = 0; i < LANES; i++) begin
            if (!be_n[i]) model_mem[a[7:0]][8*i +: 8] = tb_wdata[8*i +: 8];
          end
        end else begin
          model_err = 1'b1;
        end
      end else if (!oe) begin
        e.data = (a < DEPTH) ? model_mem[a[7:0]] : '0;
        e.due  = cycle + READ_LAT;
        sb_q.push_back(e);
        if (a >= DEPTH) model_err = 1'b1;
      end
    end
    @(posedge Clk);
    cycle++;
    if (clr_cnt < DEPTH) begin
      clr_cnt++;
      if (clr_cnt == DEPTH) begin
        for (int j = 0; j < DEPTH; j++) model_mem[j] = '0;
      end
    end
    #1;
    check_output();
  endtask

  task automatic set_idle();
    ce     = 1'b1;
    oe     = 1'b1;
    we     = 1'b1;
    be_n   = '0;
    tb_drv = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_bus", io_bus, '1);
    sb_q.delete();
    clr_cnt   = 0;
    model_err = 1'b0;
    set_idle();
    @(posedge Clk);
    #1;
    check("rst_hold_ready", ready, 1'b0);
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic apply_stimulus_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                      input logic [LANES-1:0] be, input logic oe_val);
    a        = addr;
    tb_wdata = data;
    be_n     = be;
    ce       = 1'b0;
    we       = 1'b0;
    oe       = oe_val;
    tb_drv   = 1'b1;
    tick();
    set_idle();
  endtask

  task automatic apply_stimulus_read(input logic [ADDR_W-1:0] addr, input logic [LANES-1:0] be, input int n);
    a      = addr;
    be_n   = be;
    ce     = 1'b0;
    oe     = 1'b0;
    we     = 1'b1;
    tb_drv = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cycle     = 0;
    clr_cnt   = 0;
    model_err = 1'b0;
    a         = '0;
    tb_wdata  = '0;
    set_idle();

    apply_reset();

    // Partial clear with reads attempted mid-sequence, then restart by reset.
    idle_ticks(50);
    apply_stimulus_read(20'h0, 2'b00, 3);
    idle_ticks(47);
    apply_reset();
    idle_ticks(DEPTH);
    $display("[TB] clear sequence complete at cycle %0d", cycle);

    apply_stimulus_read(20'h0, 2'b00, 4);
    idle_ticks(3);

    apply_stimulus_write(20'h10, 16'hBEEF, 2'b00, 1'b1);
    apply_stimulus_read(20'h10, 2'b00, 2);
    oe = 1'b1;
    #1;
    check("bus_oe_off", io_bus, '1);
    check("rd_valid_oe_off", rd_valid, 1'b1);
    idle_ticks(3);

    apply_stimulus_write(20'h5, 16'h1234, 2'b00, 1'b1);
    apply_stimulus_write(20'h5, 16'hAB00, 2'b01, 1'b1);
    apply_stimulus_read(20'h5, 2'b00, 2);
    idle_ticks(2);
    apply_stimulus_read(20'h5, 2'b10, 2);
    idle_ticks(2);

    apply_stimulus_write(20'h0, 16'h5A5A, 2'b00, 1'b0);
    idle_ticks(2);
    apply_stimulus_write(20'h00100, 16'hFFFF, 2'b00, 1'b1);
    idle_ticks(2);
    apply_stimulus_read(20'h0, 2'b00, 2);
    idle_ticks(2);
    apply_stimulus_read(20'h00100, 2'b00, 2);
    idle_ticks(2);

    for (int n = 0; n < 8; n++) begin
      apply_stimulus_write(ADDR_W'(n), DATA_W'(n * 16'h1111), 2'b00, 1'b1);
    end
    for (int n = 0; n < 8; n++) begin
      apply_stimulus_read(ADDR_W'(n), 2'b00, 1);
    end
    idle_ticks(3);

    // Reset with reads in flight while the bus is being driven.
    apply_stimulus_read(20'h10, 2'b00, 2);
    apply_reset();
    idle_ticks(DEPTH);
    apply_stimulus_read(20'h10, 2'b00, 2);
    idle_ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
